// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Frame parser behind the UART receiver. It looks for SYNC_BYTE and then
//   collects a frame of the form ID, LEN, LEN payload bytes and CHK.
//   CHK is the 8-bit sum of ID, LEN and the payload.
//   When a frame checks out, its fields are copied into registered outputs
//   and o_frame_valid pulses for one cycle. The parser drops bad frames and
//   reports each one with a one-cycle error strobe: checksum error, length
//   error, or inter-byte timeout.
//
// Ports
//   i_clk, i_rst_n      clock; synchronous active-low reset
//   i_rx_dv, i_rx_byte  one-cycle byte strobe and data from the receiver
//   o_frame_valid       one-cycle pulse when the fields below are updated
//   o_frame_id/len      ID and payload length of the last good frame
//   o_payload           payload of the last good frame, byte k at [8k+7:8k]
//   o_crc_err           one-cycle pulse, checksum mismatch
//   o_len_err           one-cycle pulse, LEN > MAX_LEN
//   o_timeout_err       one-cycle pulse, inter-byte timeout inside a frame
//   o_err_count         count of error pulses, saturates at 255
module uart_frame_parser #(
    parameter int         MAX_LEN      = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'hAA,
    parameter int         TIMEOUT_CLKS = 65_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx_dv,
    input  logic [7:0]           i_rx_byte,
    output logic                 o_frame_valid,
    output logic [7:0]           o_frame_id,
    output logic [3:0]           o_frame_len,
    output logic [8*MAX_LEN-1:0] o_payload,
    output logic                 o_crc_err,
    output logic                 o_len_err,
    output logic                 o_timeout_err,
    output logic [7:0]           o_err_count
);

    localparam int TW = $clog2(TIMEOUT_CLKS);

    typedef enum logic [2:0] {
        HUNT, GET_ID, GET_LEN, GET_PAYLOAD, GET_CHK
    } state_t;

    state_t state, state_d;

    logic [7:0]                 id_sh;
    logic [3:0]                 len_sh;
    logic [3:0]                 idx;
    logic [7:0]                 sum;
    logic [MAX_LEN-1:0][7:0]    shadow;
    logic [TW-1:0]              tmo_cnt;
    logic                       tmo_hit;
    logic                       good_d, crc_d, len_d, tmo_d;

    // The counter is held at 0 in HUNT, so it can only expire inside a frame.
    assign tmo_hit = (state != HUNT) && (tmo_cnt == TW'(TIMEOUT_CLKS - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= HUNT;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        good_d  = 1'b0;
        crc_d   = 1'b0;
        len_d   = 1'b0;
        tmo_d   = 1'b0;
        case (state)
            HUNT:        if (i_rx_dv && i_rx_byte == SYNC_BYTE) state_d = GET_ID;
            GET_ID:      if (i_rx_dv) state_d = GET_LEN;
            GET_LEN: if (i_rx_dv) begin
                if (i_rx_byte > 8'(MAX_LEN)) begin
                    len_d   = 1'b1;
                    state_d = HUNT;
                end else if (i_rx_byte == 8'd0) begin
                    state_d = GET_CHK;
                end else begin
                    state_d = GET_PAYLOAD;
                end
            end
            // SYNC_BYTE is ordinary data here; there is no resync.
            GET_PAYLOAD: if (i_rx_dv && idx == len_sh - 4'd1) state_d = GET_CHK;
            GET_CHK: if (i_rx_dv) begin
                if (i_rx_byte == sum) good_d = 1'b1;
                else                  crc_d  = 1'b1;
                state_d = HUNT;
            end
            default:     state_d = HUNT;
        endcase
        // When a byte arrives in the same cycle the counter expires, the byte
        // is processed and no timeout is raised.
        if (!i_rx_dv && tmo_hit) begin
            tmo_d   = 1'b1;
            state_d = HUNT;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            id_sh         <= '0;
            len_sh        <= '0;
            idx           <= '0;
            sum           <= '0;
            shadow        <= '0;
            tmo_cnt       <= '0;
            o_frame_valid <= 1'b0;
            o_crc_err     <= 1'b0;
            o_len_err     <= 1'b0;
            o_timeout_err <= 1'b0;
            o_frame_id    <= '0;
            o_frame_len   <= '0;
            o_payload     <= '0;
            o_err_count   <= '0;
        end else begin
            o_frame_valid <= good_d;
            o_crc_err     <= crc_d;
            o_len_err     <= len_d;
            o_timeout_err <= tmo_d;

            if (i_rx_dv || state_d == HUNT) tmo_cnt <= '0;
            else                            tmo_cnt <= tmo_cnt + TW'(1);

            if (i_rx_dv) begin
                case (state)
                    GET_ID: begin
                        id_sh <= i_rx_byte;
                        sum   <= i_rx_byte;
                    end
                    GET_LEN: if (i_rx_byte <= 8'(MAX_LEN)) begin
                        len_sh <= i_rx_byte[3:0];
                        sum    <= sum + i_rx_byte;
                        idx    <= '0;
                        // Clear the buffer so bytes beyond LEN read back as 0.
                        shadow <= '0;
                    end
                    GET_PAYLOAD: begin
                        for (int k = 0; k < MAX_LEN; k++)
                            if (idx == 4'(k)) shadow[k] <= i_rx_byte;
                        sum <= sum + i_rx_byte;
                        idx <= idx + 4'd1;
                    end
                    default: ;
                endcase
            end

            if (good_d) begin
                o_frame_id  <= id_sh;
                o_frame_len <= len_sh;
                o_payload   <= shadow;
            end

            if ((crc_d || len_d || tmo_d) && o_err_count != 8'hFF)
                o_err_count <= o_err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Testbench for uart_frame_parser. A table of byte sequences is applied, each
// with the expected strobe counts, output fields and error count. After that,
// hand-written sequences cover timeout latency, a byte arriving at the moment
// of expiry, error-count saturation, and reset in the middle of a frame.
// TIMEOUT_CLKS is reduced here so the timeout cases run quickly.
module tb_uart_frame_parser;

    localparam int MAX_LEN = 8;
    localparam int TMO     = 40;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 rx_dv;
    logic [7:0]           rx_byte;
    logic                 frame_valid, crc_err, len_err, timeout_err;
    logic [7:0]           frame_id, err_count;
    logic [3:0]           frame_len;
    logic [8*MAX_LEN-1:0] payload;

    uart_frame_parser #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hAA), .TIMEOUT_CLKS(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte),
        .o_frame_valid(frame_valid), .o_frame_id(frame_id), .o_frame_len(frame_len),
        .o_payload(payload), .o_crc_err(crc_err), .o_len_err(len_err),
        .o_timeout_err(timeout_err), .o_err_count(err_count)
    );

    always #5 clk = ~clk;

    // Count high cycles of each strobe. A strobe that stays high for two
    // cycles is counted twice.
    int n_val = 0, n_crc = 0, n_len = 0, n_tmo = 0;
    always @(negedge clk) begin
        if (frame_valid) n_val++;
        if (crc_err)     n_crc++;
        if (len_err)     n_len++;
        if (timeout_err) n_tmo++;
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_dv = 1'b1; rx_byte = b;
        @(posedge clk); #1;
        rx_dv = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    typedef struct {
        string      name;
        int         n;
        logic [7:0] b[12];
        int         nv, nc, nl;
        logic [7:0] id;
        logic [3:0] len;
        logic [63:0] pl;
        logic [7:0] err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int v0, c0, l0, t0, k;

        vecs[0] = '{"good", 7, '{8'hAA,8'h01,8'h03,8'h10,8'h20,8'h30,8'h64,0,0,0,0,0},
                    1, 0, 0, 8'h01, 4'd3, 64'h0000_0000_0030_2010, 8'd0};
        vecs[1] = '{"badchk", 7, '{8'hAA,8'h01,8'h03,8'h10,8'h20,8'h30,8'h65,0,0,0,0,0},
                    0, 1, 0, 8'h01, 4'd3, 64'h0000_0000_0030_2010, 8'd1};
        vecs[2] = '{"good2", 5, '{8'hAA,8'h02,8'h01,8'h7F,8'h82,0,0,0,0,0,0,0},
                    1, 0, 0, 8'h02, 4'd1, 64'h7F, 8'd1};
        vecs[3] = '{"lenerr", 6, '{8'hAA,8'h01,8'h09,8'h05,8'h00,8'h05,0,0,0,0,0,0},
                    0, 0, 1, 8'h02, 4'd1, 64'h7F, 8'd2};
        vecs[4] = '{"zerolen", 4, '{8'hAA,8'h05,8'h00,8'h05,0,0,0,0,0,0,0,0},
                    1, 0, 0, 8'h05, 4'd0, 64'h0, 8'd2};
        vecs[5] = '{"garb_syncdata", 9, '{8'h00,8'hFF,8'h55,8'hAA,8'h03,8'h02,8'hAA,8'h55,8'h04,0,0,0},
                    1, 0, 0, 8'h03, 4'd2, 64'h55AA, 8'd2};
        vecs[6] = '{"maxlen", 12, '{8'hAA,8'h07,8'h08,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h33},
                    1, 0, 0, 8'h07, 4'd8, 64'h0807_0605_0403_0201, 8'd2};
        vecs[7] = '{"shortafter", 6, '{8'hAA,8'h09,8'h02,8'h11,8'h22,8'h3E,0,0,0,0,0,0},
                    1, 0, 0, 8'h09, 4'd2, 64'h2211, 8'd2};

        rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
        idle(3);
        chk("rst_id", frame_id, 0);
        chk("rst_len", frame_len, 0);
        chk("rst_payload", payload, 0);
        chk("rst_err", err_count, 0);
        chk("rst_strobes", {frame_valid, crc_err, len_err, timeout_err}, 0);
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 8; i++) begin
            v0 = n_val; c0 = n_crc; l0 = n_len;
            for (int j = 0; j < vecs[i].n; j++) send(vecs[i].b[j]);
            idle(2);
            chk({vecs[i].name, "_nvalid"}, n_val - v0, vecs[i].nv);
            chk({vecs[i].name, "_ncrc"}, n_crc - c0, vecs[i].nc);
            chk({vecs[i].name, "_nlen"}, n_len - l0, vecs[i].nl);
            chk({vecs[i].name, "_id"}, frame_id, vecs[i].id);
            chk({vecs[i].name, "_len"}, frame_len, vecs[i].len);
            chk({vecs[i].name, "_payload"}, payload, vecs[i].pl);
            chk({vecs[i].name, "_err"}, err_count, vecs[i].err);
        end

        // Timeout latency: the pulse is seen TMO clocks after the 01 byte.
        t0 = n_tmo;
        send(8'hAA); send(8'h01);
        k = 0;
        while (k < 2 * TMO) begin
            @(posedge clk); #1; k++;
            if (timeout_err) break;
        end
        chk("tmo_latency", k, TMO);
        idle(2);
        chk("tmo_count", n_tmo - t0, 1);
        chk("tmo_err", err_count, 3);
        chk("tmo_id_hold", frame_id, 8'h09);
        // After the timeout the parser is back in HUNT, so 03 .. is ignored.
        v0 = n_val;
        send(8'h03); send(8'h00); send(8'h03);
        idle(2);
        chk("tmo_hunt_novalid", n_val - v0, 0);

        // A byte arriving in the expiry cycle is accepted and the timeout is not raised.
        t0 = n_tmo; v0 = n_val;
        send(8'hAA); send(8'h01);
        idle(TMO - 1);
        send(8'h03); send(8'h10); send(8'h20); send(8'h30); send(8'h64);
        idle(2);
        chk("dvwins_notmo", n_tmo - t0, 0);
        chk("dvwins_valid", n_val - v0, 1);
        chk("dvwins_id", frame_id, 8'h01);

        // Saturation: the counter must stop at 255.
        for (int i = 0; i < 260; i++) begin send(8'hAA); send(8'h01); send(8'h09); end
        idle(2);
        chk("sat_err", err_count, 8'hFF);
        send(8'hAA); send(8'h01);
        idle(TMO + 3);
        chk("sat_after_tmo", err_count, 8'hFF);

        // Reset in the middle of a frame: the partial frame is dropped with no error pulse.
        c0 = n_crc; l0 = n_len; t0 = n_tmo;
        send(8'h00); send(8'hFF); send(8'h55);
        send(8'hAA); send(8'h01); send(8'h03); send(8'h10);
        rst_n = 1'b0;
        idle(2);
        chk("mrst_id", frame_id, 0);
        chk("mrst_len", frame_len, 0);
        chk("mrst_payload", payload, 0);
        chk("mrst_err", err_count, 0);
        chk("mrst_noerr", (n_crc - c0) + (n_len - l0) + (n_tmo - t0), 0);
        rst_n = 1'b1;
        idle(1);
        v0 = n_val;
        send(8'hAA); send(8'h01); send(8'h03); send(8'h10); send(8'h20); send(8'h30); send(8'h64);
        idle(2);
        chk("post_rst_valid", n_val - v0, 1);
        chk("post_rst_id", frame_id, 8'h01);
        chk("post_rst_payload", payload, 64'h0030_2010);
        chk("post_rst_err", err_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
